// File: rtl/imem_loader.sv
// Instruction memory loader: packs a little-endian byte stream (LEN, words, CSUM) into
// 32-bit words and writes them to imem. It holds the CPU in reset until the image is verified.
module imem_loader #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          reload,
    output logic          imem_we,
    output logic [31:0]   imem_wr_addr,
    output logic [31:0]   imem_wr_data,
    output logic          cpu_reset,
    output logic [31:0]   start_address,
    output logic          done,
    output logic          error,
    output logic [1:0]    err_code,
    output logic [CW-1:0] words_loaded
);

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t         state;
    logic [1:0]     byte_cnt;
    logic [23:0]    asm_reg;
    logic [CW-1:0]  len_reg;
    logic [31:0]    checksum;

    logic           accept;
    logic           last_byte;
    logic [31:0]    word;

    assign in_ready      = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
    assign accept        = in_valid && in_ready;
    assign last_byte     = accept && (byte_cnt == 2'd3);
    // The 4th byte goes straight into the word so it can be used in the cycle it arrives.
    assign word          = {in_data, asm_reg};
    assign start_address = BASE_ADDR;

    // Lower three byte lanes of the assembly register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            asm_reg <= '0;
        end else if (accept) begin
            for (int i = 0; i < 3; i++) begin
                if (byte_cnt == 2'(i)) begin
                    asm_reg[8*i +: 8] <= in_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_LEN;
            byte_cnt     <= 2'd0;
            len_reg      <= '0;
            checksum     <= 32'd0;
            imem_we      <= 1'b0;
            imem_wr_addr <= 32'd0;
            imem_wr_data <= 32'd0;
            cpu_reset    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            err_code     <= 2'b00;
            words_loaded <= '0;
        end else begin
            imem_we <= 1'b0;
            if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
            end

            case (state)
                S_LEN: begin
                    if (last_byte) begin
                        byte_cnt <= 2'd0;
                        if (word > DEPTH_W) begin
                            state    <= S_ERROR;
                            error    <= 1'b1;
                            err_code <= 2'b01;
                        end else if (word == 32'd0) begin
                            len_reg <= '0;
                            state   <= S_CSUM;
                        end else begin
                            len_reg <= word[CW-1:0];
                            state   <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (last_byte) begin
                        imem_we      <= 1'b1;
                        imem_wr_addr <= BASE_ADDR + (32'(words_loaded) << 2);
                        imem_wr_data <= word;
                        words_loaded <= words_loaded + CW'(1);
                        checksum     <= checksum + word;
                        if (words_loaded + CW'(1) == len_reg) begin
                            byte_cnt <= 2'd0;
                            state    <= S_CSUM;
                        end
                    end
                end

                S_CSUM: begin
                    if (last_byte) begin
                        byte_cnt <= 2'd0;
                        if (word == checksum) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state    <= S_ERROR;
                            error    <= 1'b1;
                            err_code <= 2'b10;
                        end
                    end
                end

                S_DONE, S_ERROR: begin
                    if (reload) begin
                        state        <= S_LEN;
                        cpu_reset    <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        err_code     <= 2'b00;
                        words_loaded <= '0;
                        checksum     <= 32'd0;
                        byte_cnt     <= 2'd0;
                        len_reg      <= '0;
                    end
                end

                default: begin
                    state <= S_LEN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames with and without gaps, wrap-around checksum,
// length overflow, mid-frame reset and reload.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        reload = 1'b0;
    logic        imem_we;
    logic [31:0] imem_wr_addr;
    logic [31:0] imem_wr_data;
    logic        cpu_reset;
    logic [31:0] start_address;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [10:0] words_loaded;

    int errors = 0;
    int checks = 0;

    logic [31:0] fw [0:3];
    logic [31:0] wr_addr_log [0:31];
    logic [31:0] wr_data_log [0:31];
    int          wr_cnt = 0;

    imem_loader #(.DEPTH(1024), .BASE_ADDR(BASE)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .reload        (reload),
        .imem_we       (imem_we),
        .imem_wr_addr  (imem_wr_addr),
        .imem_wr_data  (imem_wr_data),
        .cpu_reset     (cpu_reset),
        .start_address (start_address),
        .done          (done),
        .error         (error),
        .err_code      (err_code),
        .words_loaded  (words_loaded)
    );

    always #5 clk = ~clk;

    // Every cycle with imem_we high is logged, so a stretched strobe shows up as an extra write.
    always @(negedge clk) begin
        if (imem_we && wr_cnt < 32) begin
            wr_addr_log[wr_cnt] = imem_wr_addr;
            wr_data_log[wr_cnt] = imem_wr_data;
            $display("write %0d: addr=%h data=%h", wr_cnt, imem_wr_addr, imem_wr_data);
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        if (gap) repeat ($urandom_range(1, 5)) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'hA5;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], gap);
        end
    endtask

    task automatic send_frame(input int n, input logic [31:0] csum, input bit gap);
        send_word(32'(n), gap);
        for (int i = 0; i < n; i++) begin
            send_word(fw[i], gap);
        end
        send_word(csum, gap);
    endtask

    function automatic logic [31:0] sum_words(input int n);
        logic [31:0] s = 32'd0;
        for (int i = 0; i < n; i++) s = s + fw[i];
        return s;
    endfunction

    task automatic check_writes(input string tag, input int start, input int n);
        check($sformatf("%s_count", tag), 32'(wr_cnt - start), 32'(n));
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_addr_log[start + i], BASE + 32'(4 * i));
            check($sformatf("%s_data%0d", tag, i), wr_data_log[start + i], fw[i]);
        end
    endtask

    task automatic pulse_reload(input string tag);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_words"}, 32'(words_loaded), 32'd0);
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_we"}, 32'(imem_we), 32'd0);
        check({tag, "_addr"}, imem_wr_addr, 32'd0);
        check({tag, "_data"}, imem_wr_data, 32'd0);
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_err_code"}, 32'(err_code), 32'd0);
        check({tag, "_words"}, 32'(words_loaded), 32'd0);
        check({tag, "_start"}, start_address, BASE);
    endtask

    task automatic check_done(input string tag, input int n);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_words"}, 32'(words_loaded), 32'(n));
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        int start;

        #2 reset = 1'b1;
        #1 check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Basic three-word program; checksum 0x00308359 is the plain sum of the three words.
        fw[0] = 32'h0000_0093; fw[1] = 32'h0010_0113; fw[2] = 32'h0020_81B3;
        check("t1_sum_model", sum_words(3), 32'h0030_8359);
        start = wr_cnt;
        send_frame(3, 32'h0030_8359, 1'b0);
        check_done("t1", 3);
        send_byte(8'h11, 1'b0);
        check("t1_ignore_valid", 32'(words_loaded), 32'd3);
        check_writes("t1", start, 3);
        $display("t1 basic frame done=%0d words=%0d", done, words_loaded);

        // Same frame with idle gaps; a reload pulse mid-frame must be ignored.
        pulse_reload("reload1");
        start = wr_cnt;
        send_word(32'd3, 1'b1);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check("t2_reload_ignored", 32'(cpu_reset), 32'd1);
        for (int i = 0; i < 3; i++) send_word(fw[i], 1'b1);
        send_word(32'h0030_8359, 1'b1);
        check_done("t2", 3);
        check_writes("t2", start, 3);
        $display("t2 gapped frame done=%0d words=%0d", done, words_loaded);

        // Wrap-around checksum, good then bad.
        pulse_reload("reload2");
        fw[0] = 32'hFFFF_FFFF; fw[1] = 32'h0000_0002;
        start = wr_cnt;
        send_frame(2, 32'h0000_0001, 1'b0);
        check_done("t4a", 2);
        check_writes("t4a", start, 2);
        $display("t4a wrap checksum done=%0d", done);

        pulse_reload("reload3");
        send_frame(2, 32'h0000_0002, 1'b0);
        check("t4b_error", 32'(error), 32'd1);
        check("t4b_err_code", 32'(err_code), 32'd2);
        check("t4b_done", 32'(done), 32'd0);
        check("t4b_cpu_reset", 32'(cpu_reset), 32'd1);
        $display("t4b bad checksum error=%0d code=%0d", error, err_code);

        // Length one past DEPTH.
        pulse_reload("reload4");
        start = wr_cnt;
        send_word(32'd1025, 1'b0);
        check("t3_error", 32'(error), 32'd1);
        check("t3_err_code", 32'(err_code), 32'd1);
        check("t3_ready", 32'(in_ready), 32'd0);
        check("t3_cpu_reset", 32'(cpu_reset), 32'd1);
        repeat (3) @(negedge clk);
        check("t3_no_write", 32'(wr_cnt - start), 32'd0);
        $display("t3 oversize length error=%0d code=%0d", error, err_code);

        // Reset in the middle of the second word.
        pulse_reload("reload5");
        fw[0] = 32'hAABB_CCDD;
        send_word(32'd2, 1'b0);
        send_word(32'hAABB_CCDD, 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h33, 1'b0);
        check("t5_pre_words", 32'(words_loaded), 32'd1);
        reset = 1'b1;
        #1 check_reset_outputs("t5_async");
        @(negedge clk);
        reset = 1'b0;
        fw[0] = 32'h1234_5678;
        start = wr_cnt;
        send_frame(1, 32'h1234_5678, 1'b0);
        check_done("t5", 1);
        check_writes("t5", start, 1);
        $display("t5 mid-frame reset then reload words=%0d", words_loaded);

        // Empty image.
        pulse_reload("reload6");
        start = wr_cnt;
        send_frame(0, 32'h0000_0000, 1'b0);
        check_done("t6", 0);
        check("t6_no_write", 32'(wr_cnt - start), 32'd0);
        $display("t6 empty image done=%0d", done);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
